// File: rtl/prime_feed_pkg.sv
// Shared types and helpers for the prime feed pool.
package prime_feed_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // Widest statistic counter the saturating helper supports.
  localparam int unsigned SAT_W = 64;

  // A usable candidate is odd and at least 3, i.e. odd with some bit above bit 0 set.
  function automatic logic cand_valid(input logic lsb, input logic upper_nz);
    return lsb & upper_nz;
  endfunction

  // Increment that sticks at max instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max);
    return (value >= max) ? max : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/prime_slot_bank.sv
// NUM_SLOTS x WIDTH register file with one write port and a flat read bus.
module prime_slot_bank #(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned ADDR_W    = 2
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [WIDTH-1:0]           data,
  output logic [NUM_SLOTS*WIDTH-1:0] slots
);

  logic [NUM_SLOTS*WIDTH-1:0] mem;

  // Write the addressed slot; all other slots hold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem <= '0;
    end else if (we) begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        if (addr == ADDR_W'(k)) begin
          mem[k*WIDTH +: WIDTH] <= data;
        end
      end
    end
  end

  assign slots = mem;

endmodule

// File: rtl/prime_feed_pool.sv
// Pool of NUM_SLOTS prime candidates: full load on first/forced request,
// otherwise one round-robin replacement per request.
module prime_feed_pool
  import prime_feed_pkg::*;
#(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       next,
  input  logic                       refill_all,
  input  logic [WIDTH-1:0]           s_prime_tdata,
  input  logic                       s_prime_tvalid,
  output logic                       s_prime_tready,
  output logic [NUM_SLOTS*WIDTH-1:0] primes,
  output logic                       primes_ready,
  output logic [NUM_SLOTS-1:0]       slot_updated,
  output logic                       busy,
  output logic [CNT_W-1:0]           reject_cnt,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned REM_W = $clog2(NUM_SLOTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] wr_ptr;
  logic [REM_W-1:0] remaining;
  logic             init_done;

  logic             start_c;
  logic             full_c;
  logic             cand_ok_c;
  logic             handshake_c;
  logic             accept_c;
  logic             last_c;
  logic [PTR_W-1:0] ptr_inc_c;

  // Handshake qualification and next-state selection.
  always_comb begin
    state_nxt   = state;
    start_c     = 1'b0;
    full_c      = !init_done || refill_all;
    cand_ok_c   = cand_valid(s_prime_tdata[0], |s_prime_tdata[WIDTH-1:1]);
    handshake_c = (state == ST_FILL) && s_prime_tvalid && s_prime_tready;
    accept_c    = handshake_c && cand_ok_c;
    last_c      = accept_c && (remaining == REM_W'(1));
    ptr_inc_c   = (wr_ptr == PTR_W'(NUM_SLOTS - 1)) ? '0 : wr_ptr + PTR_W'(1);
    case (state)
      ST_IDLE: begin
        if (next) begin
          state_nxt = ST_FILL;
          start_c   = 1'b1;
        end
      end
      ST_FILL: begin
        if (last_c) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill bookkeeping and registered status outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr         <= '0;
      remaining      <= '0;
      init_done      <= 1'b0;
      primes_ready   <= 1'b0;
      slot_updated   <= '0;
      busy           <= 1'b0;
      s_prime_tready <= 1'b0;
    end else begin
      if (start_c) begin
        remaining      <= full_c ? REM_W'(NUM_SLOTS) : REM_W'(1);
        if (full_c) begin
          wr_ptr <= '0;
        end
        slot_updated   <= '0;
        primes_ready   <= 1'b0;
        busy           <= 1'b1;
        s_prime_tready <= 1'b1;
      end
      if (accept_c) begin
        wr_ptr       <= ptr_inc_c;
        remaining    <= remaining - REM_W'(1);
        slot_updated <= slot_updated | (NUM_SLOTS'(1) << wr_ptr);
      end
      if (last_c) begin
        primes_ready   <= 1'b1;
        init_done      <= 1'b1;
        busy           <= 1'b0;
        s_prime_tready <= 1'b0;
      end
    end
  end

  // Saturating reject and stall statistics.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      reject_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (handshake_c && !cand_ok_c) begin
        reject_cnt <= CNT_W'(sat_inc(SAT_W'(reject_cnt), SAT_W'(CNT_MAX)));
      end
      if ((state == ST_FILL) && !s_prime_tvalid) begin
        stall_cnt <= CNT_W'(sat_inc(SAT_W'(stall_cnt), SAT_W'(CNT_MAX)));
      end
    end
  end

  prime_slot_bank #(
    .WIDTH     (WIDTH),
    .NUM_SLOTS (NUM_SLOTS),
    .ADDR_W    (PTR_W)
  ) u_bank (
    .aclk    (aclk),
    .aresetn (aresetn),
    .we      (accept_c),
    .addr    (wr_ptr),
    .data    (s_prime_tdata),
    .slots   (primes)
  );

endmodule

// File: tb/tb_prime_feed_pool.sv
// Scoreboard bench for prime_feed_pool (4-slot main instance, 3-slot wrap instance).
module tb_prime_feed_pool;

  localparam int unsigned W   = 64;
  localparam int unsigned NS  = 4;
  localparam int unsigned NS3 = 3;
  localparam int unsigned CW  = 8;
  localparam int          CMAX = 255;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic            aresetn, next, refill_all, tvalid, tready, primes_ready, busy;
  logic [W-1:0]    tdata;
  logic [NS*W-1:0] primes;
  logic [NS-1:0]   slot_updated;
  logic [CW-1:0]   reject_cnt, stall_cnt;

  logic             next3, refill3, tvalid3, tready3, ready3, busy3;
  logic [W-1:0]     tdata3;
  logic [NS3*W-1:0] primes3;
  logic [NS3-1:0]   upd3;
  logic [CW-1:0]    rej3, stl3;

  prime_feed_pool #(.WIDTH(W), .NUM_SLOTS(NS), .CNT_W(CW)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .next(next), .refill_all(refill_all),
    .s_prime_tdata(tdata), .s_prime_tvalid(tvalid), .s_prime_tready(tready),
    .primes(primes), .primes_ready(primes_ready), .slot_updated(slot_updated),
    .busy(busy), .reject_cnt(reject_cnt), .stall_cnt(stall_cnt));

  prime_feed_pool #(.WIDTH(W), .NUM_SLOTS(NS3), .CNT_W(CW)) u_dut3 (
    .aclk(aclk), .aresetn(aresetn), .next(next3), .refill_all(refill3),
    .s_prime_tdata(tdata3), .s_prime_tvalid(tvalid3), .s_prime_tready(tready3),
    .primes(primes3), .primes_ready(ready3), .slot_updated(upd3),
    .busy(busy3), .reject_cnt(rej3), .stall_cnt(stl3));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model (main instance) ----------------
  logic [W-1:0]  m_slot [NS];
  logic [NS-1:0] m_upd;
  int            m_ptr, m_pend, m_rej, m_stl, m_cyc;
  bit            m_fill, m_ready, m_init;

  typedef struct {
    logic [NS*W-1:0] primes;
    logic [NS-1:0]   upd;
    int              cyc;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [NS*W-1:0] m_flat();
    logic [NS*W-1:0] r;
    for (int k = 0; k < NS; k++) r[k*W +: W] = m_slot[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) m_slot[k] = '0;
    m_upd = '0; m_ptr = 0; m_pend = 0; m_rej = 0; m_stl = 0;
    m_fill = 0; m_ready = 0; m_init = 0;
  endtask

  // Applies one clock edge of the spec's rules to the model, using the inputs now driven.
  task automatic model_edge();
    m_cyc++;
    if (!m_fill) begin
      if (next) begin
        if (!m_init || refill_all) begin
          m_pend = NS;
          m_ptr  = 0;
        end else begin
          m_pend = 1;
        end
        m_upd = '0; m_ready = 0; m_fill = 1;
      end
    end else if (tvalid) begin
      if (tdata[0] && tdata >= 3) begin
        m_slot[m_ptr] = tdata;
        m_upd[m_ptr]  = 1'b1;
        m_ptr         = (m_ptr + 1) % NS;
        m_pend--;
        if (m_pend == 0) begin
          m_fill = 0; m_ready = 1; m_init = 1;
          sbq.push_back('{primes: m_flat(), upd: m_upd, cyc: m_cyc});
        end
      end else begin
        m_rej = (m_rej < CMAX) ? m_rej + 1 : CMAX;
      end
    end else begin
      m_stl = (m_stl < CMAX) ? m_stl + 1 : CMAX;
    end
  endtask

  task automatic cycle(input bit nx, input bit ra, input bit v, input logic [W-1:0] d);
    next = nx; refill_all = ra; tvalid = v; tdata = d;
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    int unsigned sel;
    sel = $urandom_range(9);
    d = {$urandom, $urandom};
    if (sel < 6) begin
      d[0] = 1'b1;
      if (d == 1) d = 3;
    end else if (sel == 6) begin
      d = W'($urandom_range(2));
    end else begin
      d[0] = 1'b0;
    end
    return d;
  endfunction

  // ---------------- monitor: per-cycle status and completion scoreboard ----------------
  logic prev_ready = 1'b0;
  always @(negedge aclk) begin
    chk("busy", busy, m_fill);
    chk("tready", tready, m_fill);
    chk("primes_ready", primes_ready, m_ready);
    chk("reject_cnt", reject_cnt, m_rej);
    chk("stall_cnt", stall_cnt, m_stl);
    chk("primes_live", primes, m_flat());
    if (primes_ready && !prev_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_primes", primes, e.primes);
        chk("sb_slot_updated", slot_updated, e.upd);
        chk("sb_ready_latency", m_cyc - e.cyc + 1, 1);
      end
    end
    prev_ready = primes_ready;
  end

  // ---------------- 3-slot instance helpers ----------------
  task automatic req3();
    next3 = 1'b1; @(posedge aclk); #1; next3 = 1'b0;
  endtask

  task automatic beat3(input logic [W-1:0] d);
    int g;
    g = 0;
    tvalid3 = 1'b1; tdata3 = d;
    while (!tready3 && g < 20) begin @(posedge aclk); #1; g++; end
    if (!tready3) chk("beat3_timeout", 1, 0);
    @(posedge aclk); #1;
    tvalid3 = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    aresetn = 1'b0; next = 0; refill_all = 0; tvalid = 0; tdata = '0;
    next3 = 0; refill3 = 0; tvalid3 = 0; tdata3 = '0;
    m_cyc = 0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    chk("rst_primes", primes, 0);
    chk("rst_ready", primes_ready, 0);
    chk("rst_upd", slot_updated, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tready", tready, 0);

    // first full fill
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 3); cycle(0, 0, 1, 5); cycle(0, 0, 1, 7); cycle(0, 0, 1, 11);
    chk("first_ready", primes_ready, 1);
    chk("first_primes", primes, {64'd11, 64'd7, 64'd5, 64'd3});
    chk("first_upd", slot_updated, 4'b1111);
    cycle(0, 0, 0, 0);

    // incremental replacements
    cycle(1, 0, 0, 0); cycle(0, 0, 1, 13);
    chk("inc1_primes", primes, {64'd11, 64'd7, 64'd5, 64'd13});
    chk("inc1_upd", slot_updated, 4'b0001);
    cycle(1, 0, 0, 0); cycle(0, 0, 1, 17);
    chk("inc2_primes", primes, {64'd11, 64'd7, 64'd17, 64'd13});
    chk("inc2_upd", slot_updated, 4'b0010);

    // rejects: 4 and 1 dropped, 9 lands in slot 2
    cycle(1, 0, 0, 0); cycle(0, 0, 1, 4); cycle(0, 0, 1, 1);
    chk("rej_no_write", primes, {64'd11, 64'd7, 64'd17, 64'd13});
    cycle(0, 0, 1, 9);
    chk("rej_cnt", reject_cnt, 2);
    chk("rej_primes", primes, {64'd11, 64'd9, 64'd17, 64'd13});
    chk("rej_upd", slot_updated, 4'b0100);

    // stalls mid-fill
    cycle(1, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 0);
    chk("stall_cnt5", stall_cnt, 5);
    chk("stall_busy", busy, 1);
    chk("stall_primes", primes, {64'd11, 64'd9, 64'd17, 64'd13});
    cycle(0, 0, 1, 21);
    chk("stall_done", primes, {64'd21, 64'd9, 64'd17, 64'd13});

    // forced refill with ignored next pulses
    cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 19); cycle(0, 0, 1, 23); cycle(1, 1, 1, 29); cycle(0, 0, 1, 31);
    chk("refill_primes", primes, {64'd31, 64'd29, 64'd23, 64'd19});
    chk("refill_upd", slot_updated, 4'b1111);
    cycle(0, 0, 0, 0);
    chk("refill_idle_after", busy, 0);

    // reset during a fill, then a plain request must reload all slots
    cycle(1, 0, 0, 0); cycle(0, 0, 1, 37); cycle(0, 0, 1, 41);
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("midrst_primes", primes, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tready", tready, 0);
    chk("midrst_rej", reject_cnt, 0);
    @(posedge aclk); #1 aresetn = 1'b1;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 43); cycle(0, 0, 1, 47); cycle(0, 0, 1, 53); cycle(0, 0, 1, 59);
    chk("postrst_primes", primes, {64'd59, 64'd53, 64'd47, 64'd43});
    chk("postrst_upd", slot_updated, 4'b1111);

    // saturation of both counters
    cycle(1, 0, 0, 0);
    repeat (260) cycle(0, 0, 1, 64'd6);
    repeat (260) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 61);
    chk("sat_reject", reject_cnt, 255);
    chk("sat_stall", stall_cnt, 255);

    // randomized requests
    for (int r = 0; r < 40; r++) begin
      int guard;
      cycle(1, $urandom_range(3) == 0, 1'($urandom_range(1)), rand_data());
      guard = 0;
      while (m_fill && guard < 300) begin
        cycle($urandom_range(7) == 0, 1'($urandom_range(1)), $urandom_range(9) < 8, rand_data());
        guard++;
      end
      repeat ($urandom_range(3)) cycle(0, 0, 1'($urandom_range(1)), rand_data());
    end
    repeat (3) cycle(0, 0, 0, 0);
    chk("sb_empty", sbq.size(), 0);

    // 3-slot instance: full fill then two increments, pointer wraps 2 -> 0
    req3();
    beat3(3); beat3(5); beat3(7);
    chk("ns3_ready", ready3, 1);
    chk("ns3_full", primes3, {64'd7, 64'd5, 64'd3});
    chk("ns3_full_upd", upd3, 3'b111);
    req3(); beat3(9);
    chk("ns3_wrap", primes3, {64'd7, 64'd5, 64'd9});
    chk("ns3_wrap_upd", upd3, 3'b001);
    req3(); beat3(11);
    chk("ns3_next", primes3, {64'd7, 64'd11, 64'd9});
    chk("ns3_next_upd", upd3, 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
